// File: rtl/ours_rdy_skid.sv
// Two-entry valid/ready register slice. Upstream ready comes only from local flops,
// which breaks long combinational ready chains between producer and consumer.
module ours_rdy_skid #(
    parameter int WIDTH       = 32,
    parameter int DATA_RST    = 0,
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         main_q, main_d;
    logic [WIDTH-1:0]         skid_q, skid_d;
    logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic                     rst_hold_q, rst_hold_d;
    logic                     in_fire;
    logic                     out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != FULL) & ~rst_hold_q;
    assign occupancy = state_q;
    assign out_data  = main_q;
    assign stall_cnt = stall_cnt_q;

    // in_data only reaches state through in_fire, so an undriven bus is harmless
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;
        rst_hold_d  = 1'b0;

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_d  = in_data;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (out_valid && !out_ready && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_ONE;
        end

        // Flush wins over a simultaneous accept; the payload registers keep their contents
        if (flush) begin
            state_d     = EMPTY;
            main_d      = main_q;
            skid_d      = skid_q;
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= EMPTY;
            stall_cnt_q <= '0;
            rst_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            rst_hold_q  <= rst_hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            if (DATA_RST != 0) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

endmodule

// File: tb/tb_ours_rdy_skid.sv
// Randomised and directed bench for ours_rdy_skid, checked against a queue-based
// model of a two-deep FIFO with registered ready and a saturating stall counter.
module tb_ours_rdy_skid;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [7:0]  stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    int unsigned model_q[$];
    bit          model_hold;
    int          model_stall;

    always #5 clk = ~clk;

    ours_rdy_skid #(.WIDTH(32), .DATA_RST(0), .STALL_CNT_W(8)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock: check the state left by the previous edge, drive new inputs,
    // then advance the model to what the coming edge should produce.
    task automatic applyStimulus(input bit rstn_i, input bit flush_i, input bit valid_i,
                                 input logic [31:0] data_i, input bit ready_i, output bit fired);
        bit m_in_ready;
        bit m_out_valid;
        bit prev_in_ready;
        bit ready_toggled;
        bit in_fire;
        bit out_fire;

        @(negedge clk);
        m_in_ready  = !model_hold && (model_q.size() < 2);
        m_out_valid = (model_q.size() > 0);
        checkOutput("in_ready", in_ready, m_in_ready);
        checkOutput("out_valid", out_valid, m_out_valid);
        checkOutput("occupancy", occupancy, model_q.size());
        checkOutput("stall_cnt", stall_cnt, model_stall);
        if (m_out_valid) checkOutput("out_data", out_data, model_q[0]);

        prev_in_ready = in_ready;
        ready_toggled = (ready_i != out_ready);
        rstn      = rstn_i;
        flush     = flush_i;
        in_valid  = valid_i;
        in_data   = data_i;
        out_ready = ready_i;
        #1;
        if (ready_toggled) checkOutput("in_ready_comb", in_ready, prev_in_ready);

        in_fire  = valid_i && m_in_ready;
        out_fire = ready_i && m_out_valid;
        fired    = 1'b0;
        if (!rstn_i) begin
            model_q.delete();
            model_stall = 0;
            model_hold  = 1'b1;
        end else begin
            model_hold = 1'b0;
            if (flush_i) begin
                model_q.delete();
                model_stall = 0;
            end else begin
                if (m_out_valid && !ready_i && model_stall < 255) model_stall++;
                if (out_fire) void'(model_q.pop_front());
                if (in_fire) begin
                    model_q.push_back(data_i);
                    fired = 1'b1;
                end
            end
        end
    endtask

    initial begin
        bit          fired;
        int unsigned seq;
        bit          v;
        bit          r;

        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        model_q.delete();
        model_stall = 0;
        model_hold  = 1'b1;

        $display("[TB] reset release and streaming throughput");
        applyStimulus(1, 0, 1, 32'h1, 1, fired);
        applyStimulus(1, 0, 1, 32'h1, 1, fired);
        applyStimulus(1, 0, 1, 32'h2, 1, fired);
        applyStimulus(1, 0, 1, 32'h3, 1, fired);
        applyStimulus(1, 0, 0, 32'h0, 1, fired);

        $display("[TB] fill to FULL, hold producer, drain in order");
        applyStimulus(1, 0, 1, 32'hA, 1, fired);
        applyStimulus(1, 0, 1, 32'hB, 0, fired);
        applyStimulus(1, 0, 1, 32'hC, 0, fired);
        checkOutput("full_occ", occupancy, 2'd2);
        checkOutput("full_in_ready", in_ready, 1'b0);
        applyStimulus(1, 0, 1, 32'hC, 1, fired);
        applyStimulus(1, 0, 1, 32'hC, 1, fired);
        applyStimulus(1, 0, 0, 32'h0, 1, fired);
        applyStimulus(1, 0, 0, 32'h0, 1, fired);

        $display("[TB] stall counter saturation");
        applyStimulus(1, 0, 1, 32'hA, 0, fired);
        applyStimulus(1, 0, 1, 32'hB, 0, fired);
        for (int i = 0; i < 300; i++) applyStimulus(1, 0, 1, 32'hC, 0, fired);
        checkOutput("stall_sat", stall_cnt, 8'd255);
        checkOutput("stall_hold_data", out_data, 32'hA);

        $display("[TB] flush while FULL with a competing input");
        applyStimulus(1, 1, 1, 32'hD, 0, fired);
        applyStimulus(1, 0, 0, 32'h0, 1, fired);
        checkOutput("flush_valid", out_valid, 1'b0);
        checkOutput("flush_ready", in_ready, 1'b1);

        $display("[TB] reset asserted while FULL");
        applyStimulus(1, 0, 1, 32'hA, 0, fired);
        applyStimulus(1, 0, 1, 32'hB, 0, fired);
        applyStimulus(0, 0, 1, 32'h55, 0, fired);
        applyStimulus(1, 0, 1, 32'h77, 1, fired);
        applyStimulus(1, 0, 1, 32'h77, 1, fired);
        applyStimulus(1, 0, 0, 32'h0, 1, fired);

        $display("[TB] random handshake traffic");
        seq = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            applyStimulus(1, 0, v, v ? seq : $urandom, r, fired);
            if (fired) seq++;
        end
        applyStimulus(1, 0, 0, 32'h0, 1, fired);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
